hs_source: RTL
==============

# hs_source

Valid/ready stream transmitter: the producing end of the team's single-beat valid/ready handshake, driving the input side of multi-cycle and pipelined stages. On a start pulse it issues a programmed number of transactions carrying an incrementing data pattern, with a configurable idle gap between beats. It obeys the hold-until-accepted rule regardless of sink back-pressure. It is used as a traffic generator in block-level benches and as an on-chip self-test source.

## Interface
- DW, 8, data width of the payload.
- CNTW, 8, width of the transaction count and the sent counter.
- GAPW, 4, width of the inter-beat gap field.
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  single-cycle request to begin a burst; ignored while busy.
- num_txn  input  CNTW  number of beats in the burst; sampled on the accepted start.
- gap  input  GAPW  idle cycles after each accepted beat; sampled on the accepted start.
- oval  output  1  payload valid toward the sink.
- odata  output  DW  payload.
- ordy  input  1  sink ready.
- busy  output  1  a burst is in progress (state not IDLE).
- done  output  1  single-cycle pulse when the burst completes.
- sent_cnt  output  CNTW  beats accepted in the current or most recent burst.

## Operation
- Reset values: oval=0, odata=0, busy=0, done=0, sent_cnt=0, state=IDLE.
- States:
  - IDLE: oval=0. On start:
    - num_txn!=0: latch num_txn and gap, clear sent_cnt, set odata=0, go to SEND.
    - num_txn==0: stay in IDLE and pulse done the next cycle.
  - SEND: oval=1. A beat is accepted (ack) when oval&ordy. On ack:
    - sent_cnt and odata increment.
    - If sent_cnt+1==num_txn: go to IDLE and pulse done.
    - Else if gap==0: remain in SEND (back-to-back beats).
    - Else: load the gap counter and go to GAP.
  - GAP: oval=0. Counts down the latched gap value; on the last gap cycle go to SEND.
- Protocol rules:
  - Once oval rises, it stays high and odata stays stable until ack.
  - oval never depends combinationally on ordy.
- Arithmetic: sent_cnt and odata wrap modulo 2^CNTW and 2^DW. odata is the zero-extended or truncated beat index.
- start while busy is ignored. Changes to num_txn and gap during a burst have no effect.
- Asynchronous reset mid-burst aborts immediately to reset values. No done pulse is generated.

## Timing
- start accepted at cycle t: oval=1 at t+1.
- Back-pressure: with ordy=0, oval holds indefinitely and odata is unchanged.
- gap=0, ordy=1: one beat per cycle; a burst of N beats occupies cycles t+1..t+N.
- gap=g, ordy=1: acks are spaced exactly g+1 cycles apart.
- done: registered, high for one cycle, in the cycle after the final ack. busy is already 0 in that cycle.
- A new start is accepted in the same cycle done is high (back-to-back bursts).
- num_txn==0: done in cycle t+1; oval is never asserted.

## Configuration
- HS_SRC_RANDGAP_EN defined:
  - Each gap length is lfsr[GAPW-1:0] & gap, so gap acts as a mask.
  - The LFSR is 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, reset seed 16'hACE1, advancing every cycle.
  - A masked value of 0 means back-to-back beats.
- Not defined: the gap is the fixed latched value, and no LFSR logic exists.

## Structure
- Package hs_pkg:
  - typedef enum logic [1:0] hs_src_st_e {S_IDLE, S_SEND, S_GAP}.
  - Constants HS_LFSR_SEED and HS_LFSR_TAPS.
- Sub-module hs_lfsr16: free-running 16-bit LFSR with async reset. Instantiated only under HS_SRC_RANDGAP_EN.

## Test plan
- Reset then idle 10 cycles -> oval=0, busy=0, done=0, sent_cnt=0 throughout.
- start, num_txn=4, gap=0, ordy=1 -> odata 0,1,2,3 in consecutive cycles t+1..t+4; done at t+5; sent_cnt=4.
- start, num_txn=3, gap=2, ordy=1 -> acks at t+1, t+4, t+7; oval low for 2 cycles between acks; done at t+8.
- num_txn=2, ordy low for 5 cycles after oval rises -> oval and odata=0 held stable 5 cycles; then beats 0 and 1; done once.
- start with num_txn=0 -> done at t+1, oval never high. A second start while busy -> ignored; sent_cnt still equals the first burst's num_txn.
- rst_n asserted mid-burst after 2 acks of 5 -> all outputs return to reset values immediately; no done. The next start runs a full 5-beat burst from odata=0.

Source files
------------

// File: rtl/hs_pkg.sv
// Shared types and constants for the valid/ready stream source.
package hs_pkg;

    localparam int unsigned HS_LFSR_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } hs_src_st_e;

    // Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0
    localparam logic [HS_LFSR_W-1:0] HS_LFSR_SEED = 16'hACE1;
    localparam logic [HS_LFSR_W-1:0] HS_LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/hs_lfsr16.sv
// Free-running 16-bit LFSR; exposes only the low OW bits as a random value.
module hs_lfsr16
    import hs_pkg::*;
#(
    parameter int unsigned OW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [OW-1:0] rnd
);

    logic [HS_LFSR_W-1:0] lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= HS_LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[HS_LFSR_W-2:0], ^(lfsr_q & HS_LFSR_TAPS)};
        end
    end

    assign rnd = lfsr_q[OW-1:0];

endmodule

// File: rtl/hs_source.sv
// Valid/ready burst generator with incrementing payload and inter-beat gap.
// Define HS_SRC_RANDGAP_EN to make the gap an LFSR-randomised mask instead of a fixed length.
module hs_source
    import hs_pkg::*;
#(
    parameter int unsigned DW   = 8,
    parameter int unsigned CNTW = 8,
    parameter int unsigned GAPW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [CNTW-1:0] num_txn,
    input  logic [GAPW-1:0] gap,
    output logic            oval,
    output logic [DW-1:0]   odata,
    input  logic            ordy,
    output logic            busy,
    output logic            done,
    output logic [CNTW-1:0] sent_cnt
);

    hs_src_st_e      state;
    logic [CNTW-1:0] num_q;
    logic [GAPW-1:0] gap_q;
    logic [GAPW-1:0] gap_cnt;
    logic [GAPW-1:0] gap_len_c;
    logic            ack_c;
    logic            last_c;

`ifdef HS_SRC_RANDGAP_EN
    logic [GAPW-1:0] lfsr_rnd;

    hs_lfsr16 #(
        .OW (GAPW)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .rnd   (lfsr_rnd)
    );

    assign gap_len_c = lfsr_rnd & gap_q;
`else
    assign gap_len_c = gap_q;
`endif

    assign ack_c  = oval & ordy;
    assign last_c = (CNTW'(sent_cnt + 1'b1) == num_q);

    // Burst FSM; oval/busy are set together with the state so they never depend on ordy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            oval     <= 1'b0;
            odata    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sent_cnt <= '0;
            num_q    <= '0;
            gap_q    <= '0;
            gap_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (num_txn != '0) begin
                            num_q    <= num_txn;
                            gap_q    <= gap;
                            sent_cnt <= '0;
                            odata    <= '0;
                            oval     <= 1'b1;
                            busy     <= 1'b1;
                            state    <= S_SEND;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_SEND: begin
                    if (ack_c) begin
                        sent_cnt <= CNTW'(sent_cnt + 1'b1);
                        odata    <= DW'(odata + 1'b1);
                        if (last_c) begin
                            oval  <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else if (gap_len_c != '0) begin
                            gap_cnt <= GAPW'(gap_len_c - 1'b1);
                            oval    <= 1'b0;
                            state   <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        oval  <= 1'b1;
                        state <= S_SEND;
                    end else begin
                        gap_cnt <= GAPW'(gap_cnt - 1'b1);
                    end
                end
                default: begin
                    oval  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
